// File: rtl/sr_bank_writer.sv
// sr_bank_writer: drives a bank of external SR flip-flops to a masked target value,
// verifies the feedback, and re-drives up to MAX_RETRY times before flagging an error.
module sr_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] qbar_fb,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  output logic [3:0]       retry_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;
  localparam logic [3:0] MAX_R  = 4'(MAX_RETRY);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d, mask_q, mask_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d, err_bits_q, err_bits_d, mismatch;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [3:0]       retry_q, retry_d;
  // a non-complementary q/qbar pair is treated as a failed bit
  assign mismatch = mask_q & ((q_fb ^ target_q) | ~(q_fb ^ qbar_fb));
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    mask_d     = mask_q;
    s_d        = '0;
    r_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_bits_d = err_bits_q;
    retry_d    = retry_q;
    case (state_q)
      IDLE: if (req_valid) begin
        target_d   = req_data;
        mask_d     = req_mask;
        retry_d    = '0;
        err_bits_d = '0;
        state_d    = DRIVE;
      end
      DRIVE: begin
        s_d     = mask_q & target_q & ~q_fb;
        r_d     = mask_q & ~target_q & q_fb;
        state_d = SETTLE;
      end
      SETTLE: state_d = CHECK;
      CHECK: if (mismatch == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (retry_q < MAX_R) begin
        retry_d = retry_q + 4'd1;
        state_d = DRIVE;
      end else begin
        err_d      = 1'b1;
        err_bits_d = mismatch;
        state_d    = IDLE;
      end
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      target_q   <= '0;
      mask_q     <= '0;
      s_q        <= '0;
      r_q        <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      mask_q     <= mask_d;
      s_q        <= s_d;
      r_q        <= r_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
      retry_q    <= retry_d;
    end
  end
  assign req_ready = ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_bits  = err_bits_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_sr_bank_writer.sv
// tb_sr_bank_writer: directed checks of sr_bank_writer against a bench-side SR flip-flop bank
// with stuck-at-0 and broken-qbar fault injection.
module tb_sr_bank_writer;
  logic       clk = 1'b0;
  logic       clear, req_valid, req_ready, done, err;
  logic [7:0] req_data, req_mask, s, r, q_fb, qbar_fb, err_bits;
  logic [3:0] retry_cnt;
  logic [7:0] q_m, load_val, stuck0, qbar_force, cur_mask, s1, r1;
  logic       load;
  int         n_vec = 0, n_err = 0, edges;
  sr_bank_writer #(.WIDTH(8), .MAX_RETRY(3)) dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .s(s), .r(r), .q_fb(q_fb),
    .qbar_fb(qbar_fb), .done(done), .err(err), .err_bits(err_bits), .retry_cnt(retry_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (load) q_m <= load_val;
    else q_m <= ((q_m & ~r) | s) & ~stuck0;
  assign q_fb    = q_m;
  assign qbar_fb = (~q_m & ~qbar_force) | (q_m & qbar_force);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (clear === 1'b1) begin
      check("s_and_r", 32'(s & r), 32'h0);
      check("unmasked_drive", 32'((s | r) & ~cur_mask), 32'h0);
      check("done_and_err", 32'(done & err), 32'h0);
    end
  task automatic send(input logic [7:0] d, input logic [7:0] m);
    check("ready_before_accept", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_data  = d;
    req_mask  = m;
    @(posedge clk);
    cur_mask = m;
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_result(output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (n == 1) begin
        s1 = s;
        r1 = r;
      end
      if (done || err) got = 1'b1;
    end
    req_valid = 1'b0;
    check("result_timeout", 32'(got), 32'h1);
  endtask
  initial begin
    clear = 1'b0; req_valid = 1'b0; req_data = '0; req_mask = '0;
    load = 1'b1; load_val = 8'h00; stuck0 = '0; qbar_force = '0; cur_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_s", 32'(s), 32'h0);
    check("rst_r", 32'(r), 32'h0);
    check("rst_done_err", 32'({done, err}), 32'h0);
    check("rst_err_bits", 32'(err_bits), 32'h0);
    check("rst_retry", 32'(retry_cnt), 32'h0);
    load  = 1'b0;
    clear = 1'b1;
    // first edge after release accepts
    send(8'hA5, 8'hFF);
    wait_result(edges);
    check("t1_s", 32'(s1), 32'hA5);
    check("t1_r", 32'(r1), 32'h00);
    check("t1_latency", 32'(edges), 32'd3);
    check("t1_done", 32'({done, err}), 32'h2);
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_q", 32'(q_m), 32'hA5);
    check("t1_retry", 32'(retry_cnt), 32'h0);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done), 32'h0);
    send(8'h0F, 8'hF0);
    wait_result(edges);
    check("t2_s", 32'(s1), 32'h00);
    check("t2_r", 32'(r1), 32'hA0);
    check("t2_latency", 32'(edges), 32'd3);
    check("t2_done", 32'({done, err}), 32'h2);
    check("t2_q", 32'(q_m), 32'h05);
    send(8'h05, 8'hFF);
    wait_result(edges);
    check("t3_sr", 32'({s1, r1}), 32'h0);
    check("t3_latency", 32'(edges), 32'd3);
    check("t3_done", 32'({done, err}), 32'h2);
    send(8'hFF, 8'h00);
    wait_result(edges);
    check("t4_sr", 32'({s1, r1}), 32'h0);
    check("t4_latency", 32'(edges), 32'd3);
    check("t4_done", 32'({done, err}), 32'h2);
    check("t4_q", 32'(q_m), 32'h05);
    // requests offered while busy must be ignored
    send(8'h80, 8'h80);
    req_valid = 1'b1; req_data = 8'h01; req_mask = 8'h01;
    wait_result(edges);
    check("t5_s", 32'(s1), 32'h80);
    check("t5_latency", 32'(edges), 32'd3);
    check("t5_done", 32'({done, err}), 32'h2);
    check("t5_q", 32'(q_m), 32'h85);
    @(posedge clk); #1;
    check("t5_no_accept", 32'(req_ready), 32'h1);
    stuck0 = 8'h08;
    send(8'h08, 8'h08);
    wait_result(edges);
    check("t6_latency", 32'(edges), 32'd12);
    check("t6_err", 32'({done, err}), 32'h1);
    check("t6_err_bits", 32'(err_bits), 32'h08);
    check("t6_retry", 32'(retry_cnt), 32'h3);
    @(posedge clk); #1;
    check("t6_err_pulse", 32'(err), 32'h0);
    check("t6_err_bits_hold", 32'(err_bits), 32'h08);
    check("t6_retry_hold", 32'(retry_cnt), 32'h3);
    stuck0 = '0;
    qbar_force = 8'h02;
    send(8'h02, 8'h02);
    wait_result(edges);
    check("t7_latency", 32'(edges), 32'd12);
    check("t7_err", 32'({done, err}), 32'h1);
    check("t7_err_bits", 32'(err_bits), 32'h02);
    check("t7_q", 32'(q_m), 32'h87);
    qbar_force = '0;
    send(8'h00, 8'hFF);
    check("t8_err_bits_clr", 32'(err_bits), 32'h0);
    check("t8_retry_clr", 32'(retry_cnt), 32'h0);
    @(posedge clk); #1;
    check("t8_r_settle", 32'(r), 32'h87);
    #2 clear = 1'b0;
    #1;
    check("t8_rst_s", 32'(s), 32'h0);
    check("t8_rst_r", 32'(r), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("t8_no_result", 32'({done, err}), 32'h0);
    end
    check("t8_q_kept", 32'(q_m), 32'h87);
    @(negedge clk);
    clear = 1'b1;
    send(8'h00, 8'hFF);
    wait_result(edges);
    check("t9_r", 32'(r1), 32'h87);
    check("t9_latency", 32'(edges), 32'd3);
    check("t9_done", 32'({done, err}), 32'h2);
    check("t9_q", 32'(q_m), 32'h00);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
